jpeg_uart_tx: RTL and testbench
===============================

// Module: jpeg_uart_tx
// PURPOSE
//  Downstream sink of the JPEG encoder byte stream (send_data/send_data_vaild/send_data_last).
//  Buffers encoder bursts in a byte FIFO and serialises them as 8N1 UART to the PC.
//  Sits between the encoder output and the board uart_tx pin. Reports overflow and end-of-frame.
// PARAMETERS
//  CLK_FRE     50_000_000  clk frequency in Hz
//  BAUD_RATE   115200      UART bit rate; BIT_CYC = CLK_FRE/BAUD_RATE (integer divide, >=2)
//  FIFO_DEPTH  4096        byte entries; power of 2; FIFO_AW = $clog2(FIFO_DEPTH)
// PORTS
//  clk              in   1  system clock
//  rst_n            in   1  asynchronous active-low reset
//  send_data_vaild  in   1  encoder byte strobe; one byte per cycle when high, no backpressure
//  send_data_last   in   1  qualifies final byte of a JPEG frame (EOI 0xD9); valid with vaild
//  send_data        in   8  encoder byte
//  uart_tx          out  1  serial line, idle high
//  tx_busy          out  1  high while FIFO non-empty or serialiser not IDLE
//  frame_done       out  1  one-cycle pulse when stop bit of a last-tagged byte completes
//  overflow         out  1  sticky: a byte was dropped because the FIFO was full
//  fifo_level       out  FIFO_AW+1  current FIFO occupancy
// BEHAVIOUR
//  Reset (async assert, sync-released use): uart_tx=1, tx_busy=0, frame_done=0, overflow=0,
//   fifo_level=0, FIFO pointers 0, FSM=IDLE, baud and bit counters 0.
//  FIFO: 9-bit entries {last,data}. Write when send_data_vaild && !full. If vaild && full: byte
//   dropped, overflow<=1 (held until reset), even if a read occurs the same cycle.
//   Simultaneous read+write when not full: level unchanged. Pointers wrap modulo FIFO_DEPTH;
//   full = level==FIFO_DEPTH, empty = level==0.
//  Serialiser FSM (LSB first, 8N1):
//   IDLE : uart_tx=1; if !empty pop entry into shift reg + last flag -> START.
//   START: uart_tx=0 for BIT_CYC cycles -> DATA.
//   DATA : uart_tx=shift[0] for BIT_CYC cycles per bit, shift right; after bit 7 -> STOP.
//   STOP : uart_tx=1 for BIT_CYC cycles; on final cycle pulse frame_done if last flag set;
//          -> IDLE. No extra idle cycle required: if FIFO non-empty, pop in IDLE next cycle.
//  Latency: byte written into empty FIFO at edge N -> popped at edge N+1 -> uart_tx falls at
//   edge N+2. Frame time per byte = 10*BIT_CYC + 1 cycles (one IDLE pop cycle).
//  Baud counter counts 0..BIT_CYC-1; reloads at each bit boundary; cleared in IDLE.
//  send_data_last without vaild is ignored. Back-to-back frames allowed; last flag per byte.
//  Reset mid-byte: line returns high immediately; FIFO contents discarded.
//  tx_busy registered: = !empty || state!=IDLE, evaluated on next-state values.
// STRUCTURE
//  Package jpeg_uart_pkg: typedef enum {IDLE,START,DATA,STOP} uart_state_t; localparam
//   function calc_bit_cyc(CLK_FRE,BAUD_RATE); byte-entry typedef {logic last; logic [7:0] d}.
//  Sub-module jpeg_byte_fifo (sync single-clock FIFO, inferred RAM, registered read,
//   full/empty/level, drop-on-full + overflow flag). Top holds baud counter and FSM.
// TESTING (use CLK_FRE=1000, BAUD_RATE=100 -> BIT_CYC=10, FIFO_DEPTH=8)
//  Single byte 0xA5 at cycle 0 -> uart_tx low at cycle 2 for 10 cycles, then bits
//   1,0,1,0,0,1,0,1 each 10 cycles, high stop 10 cycles; tx_busy drops after stop.
//  Burst 0xFF,0xD8,...,0xD9(last) of 5 consecutive bytes -> all five decoded in order,
//   frame_done single pulse at end of 5th stop bit, none earlier.
//  Burst of 12 bytes into depth 8 -> first 9 decoded (one popped before fill), overflow=1
//   stays set, fifo_level never exceeds 8.
//  rst_n low mid-DATA of byte 0x3C -> uart_tx=1, fifo_level=0, overflow=0 asynchronously;
//   after release, new byte 0x11 transmitted correctly.
//  Write and pop same cycle at level 1 -> fifo_level stays 1; no byte lost or duplicated.
//  Reference UART receiver model on uart_tx checks every byte and inter-byte timing.

Source files
------------

// File: rtl/jpeg_uart_pkg.sv
// Shared types and helpers for the JPEG byte-stream UART transmitter.
// Holds the serialiser state encoding, the FIFO entry layout and the baud divider calculation.
package jpeg_uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_t;

  typedef struct packed {
    logic       last;
    logic [7:0] d;
  } byte_entry_t;

  function automatic int calc_bit_cyc(input int clk_fre, input int baud_rate);
    return clk_fre / baud_rate;
  endfunction

endpackage

// File: rtl/jpeg_byte_fifo.sv
// Single-clock byte FIFO with registered read port, occupancy level and sticky drop-on-full flag.
// The next-cycle level is exported so the consumer can derive a registered busy flag.
module jpeg_byte_fifo #(
  parameter int DEPTH = 4096,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_wr_en,
  input  logic [8:0]    i_wr_data,
  input  logic          i_rd_en,
  output logic [8:0]    o_rd_data,
  output logic          o_empty,
  output logic [AW:0]   o_level,
  output logic [AW:0]   o_level_nxt,
  output logic          o_overflow
);

  localparam logic [AW:0]   LVL_FULL = (AW+1)'(DEPTH);
  localparam logic [AW:0]   LVL_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  logic [8:0]    r_mem [DEPTH];
  logic [8:0]    r_rd_data;
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_level;
  logic [AW:0]   w_level_nxt;
  logic          r_overflow;
  logic          w_full;
  logic          w_empty;
  logic          w_wr;
  logic          w_rd;

  assign w_full  = (r_level == LVL_FULL);
  assign w_empty = (r_level == '0);
  assign w_wr    = i_wr_en && !w_full;
  assign w_rd    = i_rd_en && !w_empty;

  always_comb begin
    w_level_nxt = r_level;
    case ({w_wr, w_rd})
      2'b10:   w_level_nxt = r_level + LVL_ONE;
      2'b01:   w_level_nxt = r_level - LVL_ONE;
      default: w_level_nxt = r_level;
    endcase
  end

  // Storage has no reset so it maps onto block RAM; only the pointers carry state.
  always_ff @(posedge i_clk) begin
    if (w_wr) r_mem[r_wr_ptr] <= i_wr_data;
    if (w_rd) r_rd_data <= r_mem[r_rd_ptr];
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_level    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_wr) r_wr_ptr <= r_wr_ptr + PTR_ONE;
      if (w_rd) r_rd_ptr <= r_rd_ptr + PTR_ONE;
      r_level <= w_level_nxt;
      if (i_wr_en && w_full) r_overflow <= 1'b1;
    end
  end

  assign o_rd_data   = r_rd_data;
  assign o_empty     = w_empty;
  assign o_level     = r_level;
  assign o_level_nxt = w_level_nxt;
  assign o_overflow  = r_overflow;

endmodule

// File: rtl/jpeg_uart_tx.sv
// Buffers JPEG encoder bytes and serialises them as 8N1 UART, LSB first.
// Flags end-of-frame after the stop bit of a last-tagged byte and latches FIFO overflow.
module jpeg_uart_tx
  import jpeg_uart_pkg::*;
#(
  parameter int CLK_FRE    = 50_000_000,
  parameter int BAUD_RATE  = 115200,
  parameter int FIFO_DEPTH = 4096,
  localparam int FIFO_AW   = $clog2(FIFO_DEPTH)
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_send_data_vaild,
  input  logic               i_send_data_last,
  input  logic [7:0]         i_send_data,
  output logic               o_uart_tx,
  output logic               o_tx_busy,
  output logic               o_frame_done,
  output logic               o_overflow,
  output logic [FIFO_AW:0]   o_fifo_level
);

  localparam int BIT_CYC = calc_bit_cyc(CLK_FRE, BAUD_RATE);
  localparam int BW      = (BIT_CYC > 1) ? $clog2(BIT_CYC) : 1;
  localparam logic [BW-1:0] BAUD_LAST = BW'(BIT_CYC - 1);
  localparam logic [BW-1:0] BAUD_ONE  = BW'(1);

  uart_state_t        r_state;
  uart_state_t        w_state_nxt;
  logic [BW-1:0]      r_baud;
  logic [2:0]         r_bit;
  logic [7:0]         r_shift;
  logic               r_last;
  logic               r_tx;
  logic               r_busy;
  logic               r_frame_done;
  logic               w_bit_end;
  logic               w_pop;
  logic               w_empty;
  logic [8:0]         w_rd_data;
  logic [FIFO_AW:0]   w_level;
  logic [FIFO_AW:0]   w_level_nxt;
  byte_entry_t        w_wr_entry;
  byte_entry_t        w_rd_entry;

  assign w_wr_entry = '{last: i_send_data_last, d: i_send_data};
  assign w_rd_entry = byte_entry_t'(w_rd_data);

  jpeg_byte_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_wr_en     (i_send_data_vaild),
    .i_wr_data   (w_wr_entry),
    .i_rd_en     (w_pop),
    .o_rd_data   (w_rd_data),
    .o_empty     (w_empty),
    .o_level     (w_level),
    .o_level_nxt (w_level_nxt),
    .o_overflow  (o_overflow)
  );

  assign w_bit_end = (r_state != IDLE) && (r_baud == BAUD_LAST);

  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    case (r_state)
      IDLE: begin
        if (!w_empty) begin
          w_pop       = 1'b1;
          w_state_nxt = START;
        end
      end
      START:   if (w_bit_end) w_state_nxt = DATA;
      DATA:    if (w_bit_end && (r_bit == 3'd7)) w_state_nxt = STOP;
      STOP:    if (w_bit_end) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // The FIFO read register settles during START, so the shift register is
  // loaded at the start-bit boundary. The line is a registered copy of the
  // state, which is why it trails the pop by one cycle.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state      <= IDLE;
      r_baud       <= '0;
      r_bit        <= '0;
      r_shift      <= '0;
      r_last       <= 1'b0;
      r_tx         <= 1'b1;
      r_busy       <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_baud       <= ((r_state == IDLE) || w_bit_end) ? '0 : r_baud + BAUD_ONE;
      r_busy       <= (w_level_nxt != '0) || (w_state_nxt != IDLE);
      r_frame_done <= (r_state == STOP) && w_bit_end && r_last;
      case (r_state)
        START:   r_tx <= 1'b0;
        DATA:    r_tx <= r_shift[0];
        default: r_tx <= 1'b1;
      endcase
      if ((r_state == START) && w_bit_end) begin
        r_shift <= w_rd_entry.d;
        r_last  <= w_rd_entry.last;
        r_bit   <= '0;
      end else if ((r_state == DATA) && w_bit_end) begin
        r_shift <= {1'b0, r_shift[7:1]};
        r_bit   <= r_bit + 3'd1;
      end
    end
  end

  assign o_uart_tx    = r_tx;
  assign o_tx_busy    = r_busy;
  assign o_frame_done = r_frame_done;
  assign o_fifo_level = w_level;

endmodule

// File: tb/tb_jpeg_uart_tx.sv
// Directed bench for jpeg_uart_tx at BIT_CYC=10, FIFO depth 8.
// A line-level receiver decodes uart_tx; the main sequence checks bytes, timing, flags and levels.
module tb_jpeg_uart_tx;

  localparam int CLK_FRE    = 1000;
  localparam int BAUD_RATE  = 100;
  localparam int FIFO_DEPTH = 8;
  localparam int BIT_CYC    = 10;
  localparam int FRAME      = 10 * BIT_CYC + 1;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       vaild;
  logic       last;
  logic [7:0] data;
  logic       tx;
  logic       busy;
  logic       fdone;
  logic       ovf;
  logic [3:0] level;

  int nVec = 0;
  int nMis = 0;
  int cyc = 0;
  int fdCount = 0;
  int maxLevel = 0;

  logic [7:0] rxData[$];
  int         rxStart[$];
  bit         rxLast[$];

  logic       mActive = 1'b0;
  int         mStart = 0;
  int         mK = 0;
  logic [7:0] mByte = 8'h00;
  logic       mFdBad = 1'b0;

  jpeg_uart_tx #(
    .CLK_FRE    (CLK_FRE),
    .BAUD_RATE  (BAUD_RATE),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) dut (
    .i_clk             (clk),
    .i_rst_n           (rst_n),
    .i_send_data_vaild (vaild),
    .i_send_data_last  (last),
    .i_send_data       (data),
    .o_uart_tx         (tx),
    .o_tx_busy         (busy),
    .o_frame_done      (fdone),
    .o_overflow        (ovf),
    .o_fifo_level      (level)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nVec++;
    assert (obs === exp) else begin
      nMis++;
      $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [7:0] d, input logic l);
    data  = d;
    last  = l;
    vaild = 1'b1;
    tick();
  endtask

  task automatic waitRx(input int n, input string tag);
    int budget = 0;
    while ((rxData.size() < n) && (budget < 20 * FRAME)) begin
      tick();
      budget++;
    end
    checkOutput(tag, rxData.size(), n);
  endtask

  task automatic popRx(output logic [7:0] d, output int s, output bit l);
    if (rxData.size() > 0) begin
      d = rxData.pop_front();
      s = rxStart.pop_front();
      l = rxLast.pop_front();
    end else begin
      d = 8'hxx;
      s = -1;
      l = 1'b0;
    end
  endtask

  // Receiver: start bit seen at offset 0, bits sampled mid-cell, frame_done
  // allowed only in the final cycle of the stop bit.
  always @(negedge clk) begin
    if (!rst_n) begin
      mActive = 1'b0;
    end else if (!mActive) begin
      if (tx === 1'b0) begin
        mActive = 1'b1;
        mStart  = cyc;
        mByte   = 8'h00;
        mFdBad  = fdone;
      end
    end else begin
      mK = cyc - mStart;
      if (mK == BIT_CYC / 2)
        checkOutput("rx_start_bit", tx, 1'b0);
      else if ((mK >= BIT_CYC + BIT_CYC / 2) && (mK < 9 * BIT_CYC) && ((mK - BIT_CYC / 2) % BIT_CYC == 0))
        mByte[(mK - BIT_CYC / 2) / BIT_CYC - 1] = tx;
      else if (mK == 9 * BIT_CYC + BIT_CYC / 2)
        checkOutput("rx_stop_bit", tx, 1'b1);
      if ((mK < 10 * BIT_CYC - 1) && fdone) mFdBad = 1'b1;
      if (mK == 10 * BIT_CYC - 1) begin
        checkOutput("rx_early_frame_done", mFdBad, 1'b0);
        rxData.push_back(mByte);
        rxStart.push_back(mStart);
        rxLast.push_back(fdone);
        mActive = 1'b0;
      end
    end
    if (fdone === 1'b1) fdCount++;
    if (int'(level) > maxLevel) maxLevel = int'(level);
  end

  initial begin
    logic [7:0] rd;
    int         rs;
    int         prevStart;
    bit         rl;
    int         e0;
    int         fdBase;
    logic [7:0] burst [5];

    rst_n = 1'b1;
    vaild = 1'b0;
    last  = 1'b0;
    data  = 8'h00;
    #1 rst_n = 1'b0;
    #1;
    checkOutput("reset_tx", tx, 1'b1);
    checkOutput("reset_busy", busy, 1'b0);
    checkOutput("reset_frame_done", fdone, 1'b0);
    checkOutput("reset_overflow", ovf, 1'b0);
    checkOutput("reset_level", level, 4'd0);
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    tick();
    checkOutput("idle_tx", tx, 1'b1);

    // Single byte 0xA5
    fdBase = fdCount;
    applyStimulus(8'hA5, 1'b0);
    e0 = cyc;
    vaild = 1'b0;
    checkOutput("single_busy_rise", busy, 1'b1);
    checkOutput("single_level_after_write", level, 4'd1);
    tick();
    checkOutput("single_level_after_pop", level, 4'd0);
    checkOutput("single_tx_before_start", tx, 1'b1);
    repeat (50) tick();
    checkOutput("single_busy_mid", busy, 1'b1);
    waitRx(1, "single_rx_count");
    popRx(rd, rs, rl);
    checkOutput("single_data", rd, 8'hA5);
    checkOutput("single_start_latency", rs - e0, 2);
    checkOutput("single_last", rl, 1'b0);
    checkOutput("single_busy_fall", busy, 1'b0);
    checkOutput("single_no_frame_done", fdCount - fdBase, 0);

    // Five-byte frame ending in EOI
    burst = '{8'hFF, 8'hD8, 8'hE0, 8'h10, 8'hD9};
    fdBase = fdCount;
    e0 = 0;
    for (int i = 0; i < 5; i++) begin
      applyStimulus(burst[i], (i == 4));
      if (i == 0) e0 = cyc;
    end
    vaild = 1'b0;
    last  = 1'b0;
    waitRx(5, "burst_rx_count");
    prevStart = e0 - 2;
    for (int i = 0; i < 5; i++) begin
      popRx(rd, rs, rl);
      checkOutput($sformatf("burst_data_%0d", i), rd, burst[i]);
      checkOutput($sformatf("burst_last_%0d", i), rl, (i == 4));
      checkOutput($sformatf("burst_spacing_%0d", i), rs - prevStart, (i == 0) ? 4 : FRAME);
      prevStart = rs;
    end
    checkOutput("burst_frame_done_count", fdCount - fdBase, 1);

    // Twelve bytes into a depth-8 FIFO
    maxLevel = 0;
    for (int i = 0; i < 12; i++) applyStimulus(8'(8'h40 + i), 1'b0);
    vaild = 1'b0;
    checkOutput("ovf_flag_set", ovf, 1'b1);
    checkOutput("ovf_level_full", level, 4'd8);
    waitRx(9, "ovf_rx_count");
    for (int i = 0; i < 9; i++) begin
      popRx(rd, rs, rl);
      checkOutput($sformatf("ovf_data_%0d", i), rd, 8'(8'h40 + i));
    end
    repeat (FRAME + 50) tick();
    checkOutput("ovf_no_extra_bytes", rxData.size(), 0);
    checkOutput("ovf_max_level", maxLevel, 8);
    checkOutput("ovf_flag_sticky", ovf, 1'b1);
    checkOutput("ovf_level_drained", level, 4'd0);

    // Reset while 0x3C is mid-DATA and 0x77 is queued
    applyStimulus(8'h3C, 1'b0);
    applyStimulus(8'h77, 1'b0);
    vaild = 1'b0;
    repeat (30) tick();
    checkOutput("mid_data_line_low", tx, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("async_reset_tx", tx, 1'b1);
    checkOutput("async_reset_level", level, 4'd0);
    checkOutput("async_reset_overflow", ovf, 1'b0);
    checkOutput("async_reset_busy", busy, 1'b0);
    tick();
    tick();
    rst_n = 1'b1;
    repeat (FRAME + 50) tick();
    checkOutput("reset_discard_rx", rxData.size(), 0);
    fdBase = fdCount;
    applyStimulus(8'h11, 1'b1);
    e0 = cyc;
    vaild = 1'b0;
    last  = 1'b0;
    waitRx(1, "post_reset_rx_count");
    popRx(rd, rs, rl);
    checkOutput("post_reset_data", rd, 8'h11);
    checkOutput("post_reset_latency", rs - e0, 2);
    checkOutput("post_reset_last", rl, 1'b1);
    checkOutput("post_reset_frame_done_count", fdCount - fdBase, 1);

    // Stray last without vaild, then write and pop in the same cycle at level 1
    last = 1'b1;
    tick();
    last = 1'b0;
    fdBase = fdCount;
    applyStimulus(8'h5A, 1'b0);
    e0 = cyc;
    checkOutput("wrpop_level_before", level, 4'd1);
    applyStimulus(8'hC3, 1'b0);
    vaild = 1'b0;
    checkOutput("wrpop_level_same_cycle", level, 4'd1);
    waitRx(2, "wrpop_rx_count");
    popRx(rd, rs, rl);
    checkOutput("wrpop_data_0", rd, 8'h5A);
    checkOutput("wrpop_latency_0", rs - e0, 2);
    prevStart = rs;
    popRx(rd, rs, rl);
    checkOutput("wrpop_data_1", rd, 8'hC3);
    checkOutput("wrpop_spacing_1", rs - prevStart, FRAME);
    repeat (FRAME + 50) tick();
    checkOutput("wrpop_no_duplicate", rxData.size(), 0);
    checkOutput("stray_last_ignored", fdCount - fdBase, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
    $finish;
  end

endmodule
